// File: rtl/sram_ft.sv
// sram_ft: single-port SRAM with a run-time fault table (stuck-at/transition) and a clear sweep after reset
module sram_ft #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_FAULTS = 4,
  localparam int DEPTH = 1 << ADDR_W,
  localparam int IDX_W = NUM_FAULTS > 1 ? $clog2(NUM_FAULTS) : 1,
  localparam int BIT_W = DATA_W > 1 ? $clog2(DATA_W) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rwbar,
  input  logic [ADDR_W-1:0] ramaddr,
  input  logic [DATA_W-1:0] ramin,
  output logic [DATA_W-1:0] ramout,
  output logic              ready,
  input  logic              flt_we,
  input  logic [IDX_W-1:0]  flt_idx,
  input  logic [1:0]        flt_type,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [BIT_W-1:0]  flt_bit
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] ramout_q;
  logic ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [1:0] type_q [NUM_FAULTS];
  logic [ADDR_W-1:0] faddr_q [NUM_FAULTS];
  logic [BIT_W-1:0] fbit_q [NUM_FAULTS];
  logic [DATA_W-1:0] rd_d, wr_d;
  logic [1:0] ft;
  // per bit, the lowest-index live entry decides; stuck-ats act on reads, transition faults on writes
  always_comb begin
    rd_d = mem_q[ramaddr];
    wr_d = ramin;
    ft = 2'b00;
    for (int b = 0; b < DATA_W; b++) begin
      ft = 2'b00;
      for (int i = NUM_FAULTS - 1; i >= 0; i--)
        if (type_q[i] != 2'b00 && faddr_q[i] == ramaddr && int'(fbit_q[i]) == b) ft = type_q[i];
      rd_d[b] = ft == 2'b01 ? 1'b0 : ft == 2'b10 ? 1'b1 : rd_d[b];
      wr_d[b] = (ft == 2'b11 && !mem_q[ramaddr][b]) ? 1'b0 : wr_d[b];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q <= '0;
      ready_q <= 1'b0;
      ramout_q <= '0;
      for (int i = 0; i < NUM_FAULTS; i++) type_q[i] <= 2'b00;
    end else begin
      if (flt_we && int'(flt_idx) < NUM_FAULTS) begin
        type_q[flt_idx] <= flt_type;
        faddr_q[flt_idx] <= flt_addr;
        fbit_q[flt_idx] <= flt_bit;
      end
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
        cnt_q <= cnt_q + 1'b1;
        ramout_q <= '0;
        if (&cnt_q) begin
          state_q <= RUN;
          ready_q <= 1'b1;
        end
      end else begin
        ramout_q <= (cs && rwbar) ? rd_d : '0;
        if (cs && !rwbar) mem_q[ramaddr] <= wr_d;
      end
    end
  end
  assign ramout = ramout_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_sram_ft.sv
// tb_sram_ft: table-driven scoreboard bench for sram_ft at default parameters
module tb_sram_ft;
  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b0, rwbar = 1'b1, flt_we = 1'b0;
  logic [5:0] ramaddr = '0, flt_addr = '0;
  logic [7:0] ramin = '0, ramout;
  logic [1:0] flt_idx = '0, flt_type = '0;
  logic [2:0] flt_bit = '0;
  logic ready;
  int checks = 0, failures = 0;
  typedef struct {
    logic cs, rw;
    logic [5:0] addr;
    logic [7:0] din;
    logic fwe;
    logic [1:0] fidx, ftype;
    logic [5:0] faddr;
    logic [2:0] fbit;
    logic [7:0] exp;
    string name;
  } vec_t;
  vec_t vec_a[$], vec_b[$];
  logic [7:0] exp_q[$];
  string name_q[$];
  sram_ft dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rwbar(rwbar), .ramaddr(ramaddr),
    .ramin(ramin), .ramout(ramout), .ready(ready), .flt_we(flt_we),
    .flt_idx(flt_idx), .flt_type(flt_type), .flt_addr(flt_addr), .flt_bit(flt_bit)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic c, logic r, logic [5:0] a, logic [7:0] d, logic fw,
                              logic [1:0] fi, logic [1:0] ft, logic [5:0] fa, logic [2:0] fb,
                              logic [7:0] e, string n);
    vec_t v;
    v.cs = c; v.rw = r; v.addr = a; v.din = d; v.fwe = fw;
    v.fidx = fi; v.ftype = ft; v.faddr = fa; v.fbit = fb; v.exp = e; v.name = n;
    return v;
  endfunction
  function automatic vec_t rd(logic [5:0] a, logic [7:0] e, string n);
    return mk(1, 1, a, 0, 0, 0, 0, 0, 0, e, n);
  endfunction
  function automatic vec_t wr(logic [5:0] a, logic [7:0] d, string n);
    return mk(1, 0, a, d, 0, 0, 0, 0, 0, 8'h00, n);
  endfunction
  function automatic vec_t fl(logic [1:0] i, logic [1:0] t, logic [5:0] a, logic [2:0] b, string n);
    return mk(0, 1, 0, 0, 1, i, t, a, b, 8'h00, n);
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t vs[$]);
    foreach (vs[k]) begin
      cs = vs[k].cs; rwbar = vs[k].rw; ramaddr = vs[k].addr; ramin = vs[k].din;
      flt_we = vs[k].fwe; flt_idx = vs[k].fidx; flt_type = vs[k].ftype;
      flt_addr = vs[k].faddr; flt_bit = vs[k].fbit;
      exp_q.push_back(vs[k].exp);
      name_q.push_back(vs[k].name);
      tick();
      chk(name_q.pop_front(), 32'(ramout), 32'(exp_q.pop_front()));
    end
    flt_we = 1'b0; cs = 1'b0;
  endtask
  task automatic sweep(string n);
    cs = 1'b1; rwbar = 1'b1; ramaddr = 6'd9;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk({n, "_ready"}, 32'(ready), 32'(k == 64));
      if (k < 64) chk({n, "_rdout"}, 32'(ramout), 0);
    end
    cs = 1'b0;
  endtask
  initial begin
    vec_a.push_back(rd(6'd63, 8'h00, "init_rd63"));
    vec_a.push_back(wr(6'h12, 8'hA5, "wr_a5"));
    vec_a.push_back(rd(6'h12, 8'hA5, "rd_a5"));
    vec_a.push_back(mk(0, 1, 6'h12, 0, 0, 0, 0, 0, 0, 8'h00, "deselect"));
    vec_a.push_back(wr(6'h12, 8'h00, "wr_00"));
    vec_a.push_back(mk(1, 1, 6'h12, 0, 1, 2'd0, 2'b10, 6'h12, 3'd1, 8'h00, "sa1_same_cycle"));
    vec_a.push_back(rd(6'h12, 8'h02, "sa1_rd"));
    vec_a.push_back(fl(2'd0, 2'b00, 6'h12, 3'd1, "sa1_clear"));
    vec_a.push_back(rd(6'h12, 8'h00, "sa1_restored"));
    vec_a.push_back(fl(2'd2, 2'b11, 6'd5, 3'd7, "tf_prog"));
    vec_a.push_back(wr(6'd5, 8'h00, "tf_wr00"));
    vec_a.push_back(wr(6'd5, 8'hFF, "tf_wrff"));
    vec_a.push_back(rd(6'd5, 8'h7F, "tf_rd"));
    vec_a.push_back(fl(2'd2, 2'b00, 6'd5, 3'd7, "tf_clear"));
    vec_a.push_back(wr(6'd5, 8'h80, "tf_wr80"));
    vec_a.push_back(rd(6'd5, 8'h80, "tf_rd80"));
    vec_a.push_back(fl(2'd2, 2'b11, 6'd5, 3'd7, "tf_prog2"));
    vec_a.push_back(wr(6'd5, 8'h00, "tf_fall"));
    vec_a.push_back(rd(6'd5, 8'h00, "tf_fall_rd"));
    vec_a.push_back(fl(2'd0, 2'b01, 6'd9, 3'd0, "pri_e0"));
    vec_a.push_back(fl(2'd3, 2'b10, 6'd9, 3'd0, "pri_e3"));
    vec_a.push_back(wr(6'd9, 8'h01, "pri_wr01"));
    vec_a.push_back(rd(6'd9, 8'h00, "pri_rd"));
    vec_a.push_back(fl(2'd0, 2'b00, 6'd9, 3'd0, "pri_clr_e0"));
    vec_a.push_back(wr(6'd9, 8'h00, "pri_wr00"));
    vec_a.push_back(rd(6'd9, 8'h01, "pri_e3_rd"));
    vec_a.push_back(wr(6'd7, 8'h33, "mid_wr"));
    vec_a.push_back(rd(6'd7, 8'h33, "mid_rd"));
    vec_b.push_back(rd(6'd7, 8'h00, "post_rd7"));
    vec_b.push_back(rd(6'd9, 8'h00, "post_rd9_fault_cleared"));
    vec_b.push_back(rd(6'h12, 8'h00, "post_rd12"));
    vec_b.push_back(rd(6'd5, 8'h00, "post_rd5"));
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ramout", 32'(ramout), 0);
    rst_n = 1'b1;
    sweep("init");
    run(vec_a);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_ramout", 32'(ramout), 0);
    rst_n = 1'b1;
    sweep("reinit");
    run(vec_b);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_ft.md
# sram_ft

Parametrised single-port synchronous SRAM model with a built-in fault-injection table and a hardware clear-on-reset sweep. It is the next-generation memory under test for the MBIST controller. The MBIST engine and benches program stuck-at and transition faults at run time and check that march algorithms detect them. Without faults programmed, its access protocol matches the existing 64x8 `sram` (`cs`/`rwbar`, zero output when deselected), so it is a drop-in replacement at default parameters.

## Interface
Parameters:
- `ADDR_W`, default 6: address width; `DEPTH = 2**ADDR_W` words.
- `DATA_W`, default 8: word width.
- `NUM_FAULTS`, default 4: number of fault-table entries (1..16).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cs`  in  1  chip select.
- `rwbar`  in  1  1 = read, 0 = write (qualified by `cs`).
- `ramaddr`  in  ADDR_W  access address.
- `ramin`  in  DATA_W  write data.
- `ramout`  out  DATA_W  registered read data.
- `ready`  out  1  memory initialised and accepting accesses.
- `flt_we`  in  1  write one fault-table entry this cycle.
- `flt_idx`  in  clog2(NUM_FAULTS) (min 1)  entry index.
- `flt_type`  in  2  00 none, 01 stuck-at-0, 10 stuck-at-1, 11 transition fault (cell cannot rise 0->1).
- `flt_addr`  in  ADDR_W  faulty word address.
- `flt_bit`  in  clog2(DATA_W) (min 1)  faulty bit position.

## Operation
- State machine: INIT -> RUN.
  - `rst_n` = 0: state INIT, init counter 0, `ready` = 0, `ramout` = 0, all fault entries set to type 00.
  - INIT: each edge with `rst_n` = 1 writes 0 to `mem[cnt]` and increments `cnt`. After the edge that clears `DEPTH-1`, state is RUN and `ready` = 1.
  - RUN persists until `rst_n` = 0.
- While in INIT, `cs`/`rwbar` are ignored: no write occurs and `ramout` stays 0.
- Fault programming with `flt_we` = 1 is honoured in both INIT and RUN, but not while `rst_n` = 0. `flt_idx` >= `NUM_FAULTS` is ignored.
- Write (RUN, `cs` = 1, `rwbar` = 0): `mem[ramaddr]` gets `ramin`, modified by transition faults.
  - For each type-11 entry matching `ramaddr`, if the stored bit is 0 and the new bit is 1, that bit stays 0.
  - Falling transitions succeed.
  - `ramout` is 0 in the following cycle.
- Read (RUN, `cs` = 1, `rwbar` = 1): `ramout` gets `mem[ramaddr]` with stuck-at overrides applied on the read path.
  - Type 01 forces the bit to 0; type 10 forces it to 1.
  - Stuck-ats do not alter stored contents, so clearing the fault restores the true stored value.
- `cs` = 0: `ramout` gets 0; memory is unchanged.
- Multiple entries hitting the same address/bit: the lowest index wins, for both read and write overrides.
- A fault write and a memory access in the same cycle: the access uses the table contents from before the edge.
- Out-of-range `flt_bit` (>= `DATA_W`) never matches.

## Timing
- Read latency 1 cycle: address/`cs`/`rwbar` sampled at edge N; `ramout` is valid after edge N.
- Write occurs at the sampling edge. A read of the same address at edge N+1 returns the new data.
- Init sweep: `ready` rises exactly `DEPTH` edges after the first edge with `rst_n` = 1 (64 at default).
- Reset asserted mid-INIT or mid-RUN:
  - Next edge returns to INIT with `cnt` = 0 and the sweep restarts.
  - Memory contents not yet re-swept are don't-care until the sweep completes.
- Reset values: `ramout` = 0, `ready` = 0.

## Test plan
- Reset/init: hold `rst_n` = 0 for 2 cycles, release. Expect `ready` = 0 for 63 edges and 1 after edge 64. A read of address 63 then returns 0x00.
- Basic R/W, no faults: write 0xA5 to address 0x12, read it back. Expect `ramout` = 0xA5 one cycle later. Then `cs` = 0 gives `ramout` = 0x00.
- Stuck-at: program entry 0 = SA1 at address 0x12, bit 1. Write 0x00 and read: expect 0x02. Clear entry 0 and read: expect 0x00.
- Transition fault: program entry 2 = type 11 at address 5, bit 7.
  - Write 0x00, then 0xFF, read: expect 0x7F.
  - Clear the fault, write 0x80, write 0x00, read: expect 0x00.
- Priority: entry 0 = SA0 and entry 3 = SA1, both at address 9, bit 0. Write 0x01 and read: expect 0x00.
- Reset mid-run: after data is written, assert `rst_n` for 1 cycle.
  - `ready` drops and all faults clear.
  - Reads during INIT give 0.
  - After 64 edges, a read of the previously written address returns 0x00.
- Run the full bench at `ADDR_W`=4, `DATA_W`=16, `NUM_FAULTS`=1.
